fp_normalize_pack: RTL
======================

Name: fp_normalize_pack

Overview:
- Result-side stage of the small-format floating-point add/sub datapath.
- Consumes the raw sign, exponent, unnormalized mantissa sum and cancellation zero flag produced by the add/sub core.
- Normalizes sequentially: one-bit right shift on carry, or iterative one-bit-per-cycle left shift. Truncates.
- Packs the result into the 9-bit format {sign, exp[3:0], frac[3:0]} with overflow/underflow flags, behind valid/ready handshakes on both sides.

Parameters:
- EXP_W, 4, exponent width; exp 0 = zero, exp all-ones = infinity (reserved).
- FRAC_W, 4, stored fraction width; raw mantissa is FRAC_W+2 bits: [FRAC_W+1]=carry, [FRAC_W]=hidden.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  raw result available
- in_ready  output  1  block can accept; high only in IDLE
- raw_sign  input  1  sign of raw result
- raw_exp  input  EXP_W  exponent of raw result (legal range 1..2^EXP_W-2)
- raw_mant  input  FRAC_W+2  unnormalized mantissa sum incl. carry and hidden bits
- zero_in  input  1  cancellation flag from the zero detector
- out_valid  output  1  packed result valid
- out_ready  input  1  downstream accepts result
- result  output  1+EXP_W+FRAC_W  packed {sign, exp, frac}
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, result=0, overflow=0, underflow=0. in_ready=1 in the cycle after reset. Reset overrides any in-progress operation, including a held DONE result, which is discarded.
- States: IDLE, EVAL, LSHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture sign/exp/mant/zero_in into working regs and go to EVAL.
- EVAL, evaluated in priority order:
  1. zero_in=1 or mant==0: result=+0 (all zeros), flags 0. Cancellation always yields +0 regardless of raw_sign. Go to DONE.
  2. carry bit set: mant>>=1 (LSB dropped, truncation), exp+=1.
     - If the new exp equals all-ones: result={sign, all-ones, 0}, overflow=1.
     - Go to DONE.
  3. hidden bit set: already normalized; go to DONE.
  4. Otherwise go to LSHIFT.
- LSHIFT, once per cycle:
  - If hidden bit set: go to DONE.
  - Else if exp==1: result=+0, underflow=1, go to DONE. No denormals.
  - Else: mant<<=1, exp-=1, and stay.
- DONE:
  - out_valid=1; result, overflow and underflow are stable while out_valid=1.
  - result={sign, exp, mant[FRAC_W-1:0]} unless forced by a zero, overflow or underflow case.
  - On out_ready, go to IDLE next cycle and drop out_valid. in_ready returns one cycle after the handshake; there is no same-cycle turnaround.
- Flags are cleared on each new capture.
- Latency, measured from the accepting edge k:
  - out_valid is high from edge k+2 for the zero, carry and already-normalized cases.
  - For n left shifts, out_valid is high from edge k+2+n.
  - Worst case: k+2+FRAC_W.
- Throughput: one operation in flight. in_valid is ignored outside IDLE.
- out_ready held low keeps DONE indefinitely with outputs unchanged.

Test Plan:
1. Zero: zero_in=1, raw_sign=1, raw_exp=5, raw_mant=6'b000000 -> result=9'h000, overflow=0, underflow=0, out_valid at edge k+2.
2. Carry: sign=0, exp=6, mant=6'b110010 -> result=9'h079 (exp 7, frac 1001), out_valid at k+2.
3. Left shift: sign=0, exp=6, mant=6'b000101 -> two shifts, result=9'h044 (exp 4, frac 0100), out_valid at k+4, in_ready low from k+1 until after the handshake.
4. Overflow: sign=1, exp=14, mant=6'b100000 -> result=9'h1F0, overflow=1, underflow=0.
5. Underflow: sign=0, exp=2, mant=6'b000011 -> result=9'h000, underflow=1, out_valid at k+4 (EVAL, shift to exp 1, detect).
6. Backpressure then reset:
   - Hold out_ready=0 for 5 cycles in DONE -> result and flags constant, out_valid stays 1.
   - Start a new op with exp=6, mant=6'b000001 and assert rst during LSHIFT -> next cycle out_valid=0, result=0, flags 0, in_ready=1.

Source files
------------

// File: rtl/fp_normalize_pack.sv
// Result-side normalize/pack stage for the small-format FP add/sub datapath.
// Normalizes the raw mantissa sum sequentially (truncating) and packs {sign, exp, frac}.
`timescale 1ns/1ps
module fp_normalize_pack #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      raw_sign,
  input  logic [EXP_W-1:0]          raw_exp,
  input  logic [FRAC_W+1:0]         raw_mant,
  input  logic                      zero_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int M_W = FRAC_W + 2;
  localparam int R_W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_LSHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [M_W-1:0]    mant_q, mant_d;
  logic              zero_q, zero_d;
  logic [R_W-1:0]    result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic [M_W-1:0]    mant_rsh;
  logic [M_W-1:0]    mant_lsh;
  logic [EXP_W-1:0]  exp_inc;
  logic [EXP_W-1:0]  exp_dec;

  always_comb begin
    mant_rsh = mant_q >> 1;
    mant_lsh = mant_q << 1;
    exp_inc  = exp_q + EXP_ONE;
    exp_dec  = exp_q - EXP_ONE;
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    zero_d   = zero_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = raw_sign;
          exp_d   = raw_exp;
          mant_d  = raw_mant;
          zero_d  = zero_in;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        if (zero_q || (mant_q == '0)) begin
          // Cancellation always produces +0, whatever the raw sign was.
          result_d = '0;
          state_d  = S_DONE;
        end else if (mant_q[M_W-1]) begin
          mant_d  = mant_rsh;
          exp_d   = exp_inc;
          state_d = S_DONE;
          if (exp_inc == EXP_MAX) begin
            result_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc, mant_rsh[FRAC_W-1:0]};
          end
        end else if (mant_q[FRAC_W]) begin
          result_d = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
          state_d  = S_DONE;
        end else begin
          state_d = S_LSHIFT;
        end
      end

      S_LSHIFT: begin
        if (mant_q[FRAC_W]) begin
          result_d = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
          state_d  = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          // No denormals: anything that cannot reach exp 1 normalized flushes to +0.
          result_d = '0;
          udf_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          mant_d = mant_lsh;
          exp_d  = exp_dec;
          // Finish in the same cycle the hidden bit lands so n shifts cost n cycles.
          if (mant_lsh[FRAC_W]) begin
            result_d = {sign_q, exp_dec, mant_lsh[FRAC_W-1:0]};
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
